// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: divider state encoding, default widths
// and the HI/LO reset value.
package hilo_unit_pkg;

    localparam int DW_DEFAULT    = 32;
    localparam int CNT_W_DEFAULT = 6;

    localparam logic [DW_DEFAULT-1:0] HILO_RST_VAL = '0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } divState_e;

endpackage

// File: rtl/hilo_unit_div_core.sv
// Iterative restoring divider: one quotient bit per cycle over DW cycles, with
// sign fix-up applied to the outputs presented while in DONE.
module hilo_unit_div_core
    import hilo_unit_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          signed_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    input  logic          annul_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] quot_o,
    output logic [DW-1:0] rem_o
);

    divState_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]  quot_q, quot_d;
    logic [DW-1:0]  rem_q, rem_d;
    logic [DW-1:0]  divisor_q, divisor_d;
    logic           negQuot_q, negQuot_d;
    logic           negRem_q, negRem_d;

    logic [DW:0]    trial;
    logic           dividendNeg;
    logic           divisorNeg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
        end
    end

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // remainder on each step while the new quotient bit enters at the LSB.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        negQuot_d   = negQuot_q;
        negRem_d    = negRem_q;
        dividendNeg = signed_i & dividend_i[DW-1];
        divisorNeg  = signed_i & divisor_i[DW-1];
        trial       = {rem_q, quot_q[DW-1]} - {1'b0, divisor_q};

        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    if (divisor_i == '0) begin
                        quot_d    = '1;
                        rem_d     = dividend_i;
                        negQuot_d = 1'b0;
                        negRem_d  = 1'b0;
                        state_d   = DIV_DONE;
                    end else begin
                        quot_d    = dividendNeg ? -dividend_i : dividend_i;
                        divisor_d = divisorNeg ? -divisor_i : divisor_i;
                        rem_d     = '0;
                        cnt_d     = '0;
                        negQuot_d = dividendNeg ^ divisorNeg;
                        negRem_d  = dividendNeg;
                        state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    if (!trial[DW]) begin
                        rem_d  = trial[DW-1:0];
                        quot_d = {quot_q[DW-2:0], 1'b1};
                    end else begin
                        rem_d  = {rem_q[DW-2:0], quot_q[DW-1]};
                        quot_d = {quot_q[DW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DW - 1)) begin
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != DIV_IDLE);
    assign done_o = (state_q == DIV_DONE);
    assign quot_o = negQuot_q ? -quot_q : quot_q;
    assign rem_o  = negRem_q ? -rem_q : rem_q;

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO register pair with write-back writes, divider result writes
// and pipeline stall. Define HILO_BYPASS_EN to forward write-back data to hi_o/lo_o.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_whilo_i,
    input  logic [DW-1:0] wb_hi_i,
    input  logic [DW-1:0] wb_lo_i,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    input  logic          div_start_i,
    input  logic          div_signed_i,
    input  logic [DW-1:0] div_dividend_i,
    input  logic [DW-1:0] div_divisor_i,
    input  logic          div_annul_i,
    output logic          stall_o,
    output logic          div_busy_o
);

    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          divBusy;
    logic          divDone;
    logic [DW-1:0] divQuot;
    logic [DW-1:0] divRem;

    hilo_unit_div_core #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_div_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_i),
        .signed_i   (div_signed_i),
        .dividend_i (div_dividend_i),
        .divisor_i  (div_divisor_i),
        .annul_i    (div_annul_i),
        .busy_o     (divBusy),
        .done_o     (divDone),
        .quot_o     (divQuot),
        .rem_o      (divRem)
    );

    // The divide is younger than whatever sits in write-back, so its result wins.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (divDone) begin
            hi_d = divRem;
            lo_d = divQuot;
        end else if (wb_whilo_i) begin
            hi_d = wb_hi_i;
            lo_d = wb_lo_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= DW'(HILO_RST_VAL);
            lo_q <= DW'(HILO_RST_VAL);
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi_o = (wb_whilo_i && !divDone) ? wb_hi_i : hi_q;
    assign lo_o = (wb_whilo_i && !divDone) ? wb_lo_i : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

    assign stall_o    = divBusy ? !divDone : div_start_i;
    assign div_busy_o = divBusy;

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Owns the architectural HI/LO register pair.
- Receives HI/LO writes (whilo/hi/lo) from the write-back stage. Supplies the current HI/LO values to the execute stage.
- Hosts a 32-cycle iterative divider that writes HI (remainder) and LO (quotient) on completion. Stalls the pipeline while the divider runs.

Parameters:
- DW, 32, datapath width of HI, LO, dividend and divisor.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > DW.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- wb_whilo_i  in  1  write-back stage HI/LO write enable.
- wb_hi_i  in  DW  HI value to write.
- wb_lo_i  in  DW  LO value to write.
- hi_o  out  DW  current HI to execute stage.
- lo_o  out  DW  current LO to execute stage.
- div_start_i  in  1  execute stage requests a divide; honoured only in IDLE.
- div_signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- div_dividend_i  in  DW  dividend (rs); sampled with start.
- div_divisor_i  in  DW  divisor (rt); sampled with start.
- div_annul_i  in  1  abort an in-flight divide (flush/exception).
- stall_o  out  1  request pipeline stall.
- div_busy_o  out  1  divider not IDLE.

Behaviour:
- Reset (rst_n=0, async): HI=0, LO=0, state=IDLE, counter=0, working registers=0. Outputs: hi_o=0, lo_o=0, stall_o=0, div_busy_o=0. Deasserting reset mid-divide discards the divide; no HI/LO write.
- HI/LO write: with wb_whilo_i=1, HI<=wb_hi_i and LO<=wb_lo_i on the next edge. hi_o/lo_o are registered values.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - div_start_i=1 and divisor!=0: latch |dividend|, |divisor| (absolute values only when div_signed_i=1), latch sign flags, clear remainder and counter, go BUSY.
  - div_start_i=1 and divisor==0: latch quotient=all ones, remainder=dividend, go DONE.
  - stall_o = div_start_i (combinational) in IDLE.
- BUSY:
  - One restoring step per cycle: shift {rem,quot} left 1, subtract divisor from rem, keep the result if non-negative, set the quot LSB accordingly.
  - counter increments each cycle; after the step at counter=DW-1, go DONE.
  - stall_o=1.
  - div_annul_i=1: go IDLE next edge, no HI/LO write, stall_o still 1 that cycle.
- DONE:
  - Apply sign fix for signed divides: negate quotient if operand signs differ; remainder takes the dividend sign.
  - Write HI<=remainder, LO<=quotient; go IDLE. stall_o=0, so the divide instruction advances this cycle.
  - div_annul_i in DONE: ignored; the write completes.
- Latency: start at cycle 0; BUSY cycles 1..32; DONE at cycle 33; new HI/LO visible on hi_o/lo_o at cycle 34. Divide by zero: DONE at cycle 1, visible at cycle 2.
- Simultaneous DONE write and wb_whilo_i: divider result wins. The divide is the younger instruction; the wb write is dropped.
- div_start_i in BUSY/DONE: ignored.
- div_busy_o = (state != IDLE).
- Most negative / -1 signed: quotient wraps to 0x80000000, remainder 0; no trap.

Optional Feature:
- HILO_BYPASS_EN defined: hi_o/lo_o forward wb_hi_i/wb_lo_i combinationally when wb_whilo_i=1 and no same-cycle DONE write. The same-cycle reader sees the new value.
- Undefined: hi_o/lo_o are purely registered. The upstream forwarding network resolves hazards.

Decomposition:
- Shared defines package: DIV state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), DW default, HI/LO reset value.
- Sub-module div_core: sign handling, counter and restoring step, with start/annul/done/quot/rem ports.
- hilo_unit keeps the HI/LO registers, write arbitration, stall and bypass logic.

Test Plan:
- Reset, then wb_whilo_i=1, wb_hi_i=0x12345678, wb_lo_i=0x9ABCDEF0 for one cycle -> next cycle hi_o=0x12345678, lo_o=0x9ABCDEF0; stall_o=0 throughout.
- DIVU 100/7 -> stall_o high cycles 0..32, low at 33; cycle 34 hi_o=0x00000002, lo_o=0x0000000E.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF at cycle 34; DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- Divide by zero, dividend 0x55 -> DONE at cycle 1; cycle 2 lo_o=0xFFFFFFFF, hi_o=0x00000055.
- Start a divide, assert div_annul_i at cycle 10 -> state IDLE at cycle 11, stall_o=0, HI/LO unchanged. A new start at cycle 12 completes normally.
- wb_whilo_i=1 (hi=0xAAAA_AAAA) in the DONE cycle of DIVU 9/2 -> hi_o=1, lo_o=4 (divider wins). With HILO_BYPASS_EN, a wb write in IDLE appears on hi_o the same cycle.
